// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive-side monitor for a 4-digit multiplexed seven-segment display.
//   Registers the active-low anode/segment/dp pins once. It then waits for a
//   scanned digit to stay stable for SETTLE_CYCLES samples and decodes it back
//   to BCD. A per-digit snapshot is kept with valid/error/dp flags.
//
//   Optional binary conversion of each frame is enabled by defining
//   SEG_SCAN_BIN_EN. Without it, value_bin/bin_stb are tied to 0.
//
// Ports
//   clk, rst_n   clock, async active-low reset
//   an[0:3]      anodes (active-low), an[0] = digit 3 ... an[3] = digit 0
//   seg[0:6]     segments (active-low), seg[0]=G ... seg[6]=A
//   dp           decimal point (active-low)
//   digits       BCD snapshot, [15:12]=digit 3 ... [3:0]=digit 0, F = blank
//   dig_valid    per-digit snapshot valid (clears after TIMEOUT_CYCLES idle)
//   dig_err      per-digit illegal-pattern flag
//   dp_out       captured dp per digit, active-high
//   cap_stb      one-cycle pulse per capture, cap_idx = captured digit
//   frame_stb    pulse once all four digits have been captured
//   ghost_cnt    saturating count of multi-anode events
//   value_bin    binary value of last error-free frame (optional)
//   bin_stb      pulse when value_bin updates (optional)
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:3]  an,
  input  logic [0:6]  seg,
  input  logic        dp,
  output logic [15:0] digits,
  output logic [3:0]  dig_valid,
  output logic [3:0]  dig_err,
  output logic [3:0]  dp_out,
  output logic        cap_stb,
  output logic [1:0]  cap_idx,
  output logic        frame_stb,
  output logic [7:0]  ghost_cnt,
  output logic [13:0] value_bin,
  output logic        bin_stb
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int AW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_N = CW'(SETTLE_CYCLES);
  localparam logic [AW-1:0] TMO_N    = AW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  // ---------------- input sample stage ----------------
  logic [0:3] an_q;
  logic [0:6] seg_q;
  logic       dp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an;
      seg_q <= seg;
      dp_q  <= dp;
    end
  end

  logic [2:0] nlow;
  logic       sel_valid, multi;
  logic [1:0] sel_idx;

  assign nlow      = 3'($countones(~an_q));
  assign sel_valid = (nlow == 3'd1);
  assign multi     = (nlow >= 3'd2);

  always_comb begin
    sel_idx = 2'd0;
    case (an_q)
      4'b0111: sel_idx = 2'd3;
      4'b1011: sel_idx = 2'd2;
      4'b1101: sel_idx = 2'd1;
      default: sel_idx = 2'd0;
    endcase
  end

  // ---------------- pattern decode ----------------
  logic [3:0] dec_nib;
  logic       dec_ok;

  always_comb begin
    dec_nib = 4'hF;
    dec_ok  = 1'b1;
    case (seg_q)
      7'h40: dec_nib = 4'd0;
      7'h79: dec_nib = 4'd1;
      7'h24: dec_nib = 4'd2;
      7'h30: dec_nib = 4'd3;
      7'h19: dec_nib = 4'd4;
      7'h12: dec_nib = 4'd5;
      7'h02: dec_nib = 4'd6;
      7'h78: dec_nib = 4'd7;
      7'h00: dec_nib = 4'd8;
      7'h10: dec_nib = 4'd9;
      7'h7F: dec_nib = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // ---------------- settle FSM ----------------
  state_t        state, state_n;
  logic [0:3]    ld_an, ld_an_n;
  logic [0:6]    ld_seg, ld_seg_n;
  logic          ld_dp, ld_dp_n;
  logic [CW-1:0] stab_cnt, stab_cnt_n;
  logic          same, restart, cap;

  assign same = (an_q == ld_an) && (seg_q == ld_seg) && (dp_q == ld_dp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ld_an    <= 4'hF;
      ld_seg   <= 7'h7F;
      ld_dp    <= 1'b1;
      stab_cnt <= '0;
    end else begin
      state    <= state_n;
      ld_an    <= ld_an_n;
      ld_seg   <= ld_seg_n;
      ld_dp    <= ld_dp_n;
      stab_cnt <= stab_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    ld_an_n    = ld_an;
    ld_seg_n   = ld_seg;
    ld_dp_n    = ld_dp;
    stab_cnt_n = stab_cnt;
    restart    = 1'b0;
    cap        = 1'b0;
    case (state)
      S_IDLE: if (sel_valid) restart = 1'b1;
      S_SETTLE: begin
        if (same) begin
          if (stab_cnt + CW'(1) == SETTLE_N) begin
            cap     = 1'b1;
            state_n = S_HOLD;
          end else begin
            stab_cnt_n = stab_cnt + CW'(1);
          end
        end else if (sel_valid) restart = 1'b1;
        else state_n = S_IDLE;
      end
      S_HOLD: begin
        if (!same) begin
          if (sel_valid) restart = 1'b1;
          else state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // A fresh valid select counts as the first stable sample; with a
    // one-sample settle it is captured immediately.
    if (restart) begin
      ld_an_n    = an_q;
      ld_seg_n   = seg_q;
      ld_dp_n    = dp_q;
      stab_cnt_n = CW'(1);
      if (SETTLE_CYCLES <= 1) begin
        cap     = 1'b1;
        state_n = S_HOLD;
      end else begin
        state_n = S_SETTLE;
      end
    end
  end

  // ---------------- snapshot, ageing, frame tracking ----------------
  logic [3:0]    seen, seen_nx;
  logic [AW-1:0] age     [4];
  logic [AW-1:0] age_inc [4];

  assign seen_nx = seen | (4'b0001 << sel_idx);

  always_comb begin
    for (int i = 0; i < 4; i++)
      age_inc[i] = (age[i] == TMO_N) ? age[i] : age[i] + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits    <= 16'hFFFF;
      dig_valid <= '0;
      dig_err   <= '0;
      dp_out    <= '0;
      cap_stb   <= 1'b0;
      cap_idx   <= '0;
      frame_stb <= 1'b0;
      seen      <= '0;
      for (int i = 0; i < 4; i++) age[i] <= '0;
    end else begin
      cap_stb   <= cap;
      frame_stb <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (cap && sel_idx == 2'(i)) begin
          age[i]    <= '0;
          dp_out[i] <= ~dp_q;
          if (dec_ok) begin
            digits[4*i +: 4] <= dec_nib;
            dig_valid[i]     <= 1'b1;
            dig_err[i]       <= 1'b0;
          end else begin
            dig_valid[i] <= 1'b0;
            dig_err[i]   <= 1'b1;
          end
        end else begin
          age[i] <= age_inc[i];
          // Stale digit: drop valid, keep the last nibble and error flag.
          if (age_inc[i] == TMO_N) dig_valid[i] <= 1'b0;
        end
      end
      if (cap) begin
        cap_idx <= sel_idx;
        if (seen_nx == 4'hF) begin
          frame_stb <= 1'b1;
          seen      <= '0;
        end else begin
          seen <= seen_nx;
        end
      end
    end
  end

  // ---------------- multi-anode (ghost) counter ----------------
  logic multi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_q   <= 1'b0;
      ghost_cnt <= '0;
    end else begin
      multi_q <= multi;
      // Count entries into a multi-anode condition, not its duration.
      if (multi && !multi_q && ghost_cnt != 8'hFF) ghost_cnt <= ghost_cnt + 8'd1;
    end
  end

  // ---------------- optional binary conversion ----------------
`ifdef SEG_SCAN_BIN_EN
  logic [13:0] b3, b2, b1, b0, bin_sum;

  // Blank nibbles contribute zero.
  assign b3 = (digits[15:12] == 4'hF) ? 14'd0 : {10'd0, digits[15:12]};
  assign b2 = (digits[11:8]  == 4'hF) ? 14'd0 : {10'd0, digits[11:8]};
  assign b1 = (digits[7:4]   == 4'hF) ? 14'd0 : {10'd0, digits[7:4]};
  assign b0 = (digits[3:0]   == 4'hF) ? 14'd0 : {10'd0, digits[3:0]};

  // x*1000 = x*1024 - x*16 - x*8 ; x*100 = x*64 + x*32 + x*4 ; x*10 = x*8 + x*2
  assign bin_sum = ((b3 << 10) - (b3 << 4) - (b3 << 3))
                 + ((b2 << 6) + (b2 << 5) + (b2 << 2))
                 + ((b1 << 3) + (b1 << 1))
                 + b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_bin <= '0;
      bin_stb   <= 1'b0;
    end else begin
      bin_stb <= 1'b0;
      if (frame_stb && dig_err == 4'h0) begin
        value_bin <= bin_sum;
        bin_stb   <= 1'b1;
      end
    end
  end
`else
  assign value_bin = '0;
  assign bin_stb   = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
//   Self-checking bench for seg_scan_decoder (SETTLE_CYCLES=4,
//   TIMEOUT_CYCLES=50). A reference model tracks run lengths of identical
//   pin samples and per-digit capture times. It is compared against the DUT
//   on every falling edge. Directed table vectors and hand-written sequences
//   cover capture, framing, glitches, ghosts, timeout and reset.
module tb_seg_scan_decoder;
  localparam int SETTLE = 4;
  localparam int TO     = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:3]  an = 4'hF;
  logic [0:6]  seg = 7'h7F;
  logic        dp = 1'b1;
  logic [15:0] digits;
  logic [3:0]  dig_valid, dig_err, dp_out;
  logic        cap_stb, frame_stb, bin_stb;
  logic [1:0]  cap_idx;
  logic [7:0]  ghost_cnt;
  logic [13:0] value_bin;

  seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .dp(dp),
    .digits(digits), .dig_valid(dig_valid), .dig_err(dig_err), .dp_out(dp_out),
    .cap_stb(cap_stb), .cap_idx(cap_idx), .frame_stb(frame_stb),
    .ghost_cnt(ghost_cnt), .value_bin(value_bin), .bin_stb(bin_stb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [3:0] a; logic [6:0] s; logic d; } smp_t;

  logic [6:0] legal [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int sel_of(input logic [3:0] a);
    int z = 0, idx = -1;
    for (int b = 0; b < 4; b++) if (!a[b]) begin z++; idx = b; end
    return (z == 1) ? idx : -1;
  endfunction

  function automatic int nlow(input logic [3:0] a);
    int z = 0;
    for (int b = 0; b < 4; b++) if (!a[b]) z++;
    return z;
  endfunction

  smp_t       latched, prev_s, cur;
  int         run, m_now, m_ghost;
  logic [3:0] m_dig [4];
  bit   [3:0] m_vflag, m_err, m_dp, m_seen;
  int         m_ct [4];
  bit         m_cap, m_frame, m_bstb, pend;
  logic [1:0] m_idx;
  int         m_bin, pend_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latched = '{a: 4'hF, s: 7'h7F, d: 1'b1};
      prev_s = latched;
      run = 0; m_now = 0; m_ghost = 0;
      for (int i = 0; i < 4; i++) begin m_dig[i] = 4'hF; m_ct[i] = 0; end
      m_vflag = 0; m_err = 0; m_dp = 0; m_seen = 0;
      m_cap = 0; m_frame = 0; m_bstb = 0; pend = 0; m_idx = 0;
      m_bin = 0; pend_val = 0;
    end else begin
      int sel;
      bit ok;
      logic [3:0] nib;
      m_now++;
      cur = latched;
      latched = '{a: an, s: seg, d: dp};
      m_cap = 0; m_frame = 0; m_bstb = 0;
      if (pend) begin m_bin = pend_val; m_bstb = 1; pend = 0; end
      run = (cur == prev_s) ? ((run < 1000) ? run + 1 : run) : 1;
      if (nlow(cur.a) >= 2 && nlow(prev_s.a) < 2 && m_ghost < 255) m_ghost++;
      prev_s = cur;
      sel = sel_of(cur.a);
      if (sel >= 0 && run == SETTLE) begin
        ok = 0; nib = 4'hF;
        for (int k = 0; k < 10; k++) if (cur.s == legal[k]) begin ok = 1; nib = 4'(k); end
        if (cur.s == 7'h7F) ok = 1;
        m_cap = 1; m_idx = 2'(sel);
        if (ok) begin m_dig[sel] = nib; m_vflag[sel] = 1; m_err[sel] = 0; end
        else begin m_vflag[sel] = 0; m_err[sel] = 1; end
        m_dp[sel] = ~cur.d;
        m_ct[sel] = m_now;
        m_seen[sel] = 1;
        if (m_seen == 4'hF) begin
          m_frame = 1; m_seen = 0;
`ifdef SEG_SCAN_BIN_EN
          if (m_err == 0) begin
            int w = 1;
            pend = 1; pend_val = 0;
            for (int i = 0; i < 4; i++) begin
              pend_val += ((m_dig[i] == 4'hF) ? 0 : int'(m_dig[i])) * w;
              w *= 10;
            end
          end
`endif
        end
      end
    end
  end

  // Continuous comparison against the model
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      logic [3:0] ev;
      for (int i = 0; i < 4; i++) ev[i] = m_vflag[i] && ((m_now - m_ct[i]) < TO);
      chk("m_digits", 32'(digits), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
      chk("m_valid", 32'(dig_valid), 32'(ev));
      chk("m_err", 32'(dig_err), 32'(m_err));
      chk("m_dp", 32'(dp_out), 32'(m_dp));
      chk("m_cap_stb", 32'(cap_stb), 32'(m_cap));
      chk("m_cap_idx", 32'(cap_idx), 32'(m_idx));
      chk("m_frame", 32'(frame_stb), 32'(m_frame));
      chk("m_ghost", 32'(ghost_cnt), 32'(m_ghost));
      chk("m_bin", 32'(value_bin), 32'(m_bin));
      chk("m_bin_stb", 32'(bin_stb), 32'(m_bstb));
    end
  end

  // Pulse counters sampled on the rising edge (value of the previous cycle)
  int cap_cnt = 0, frame_cnt = 0, bin_cnt = 0;
  always @(posedge clk) begin
    if (cap_stb) cap_cnt++;
    if (frame_stb) frame_cnt++;
    if (bin_stb) bin_cnt++;
  end

  // Called at a falling edge; drives pins and waits n rising edges.
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    an = a; seg = s; dp = d;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  a;
    logic [6:0]  s;
    logic        d;
    int          n;
    logic [15:0] e_dig;
    logic [3:0]  e_val;
    logic [3:0]  e_dp;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, f0, b0, g0, k;
    tbl[0] = '{4'b0111, 7'h30, 1'b1, 6, 16'h3FFF, 4'b1000, 4'b0000};
    tbl[1] = '{4'b0111, 7'h79, 1'b1, 8, 16'h1FFF, 4'b1000, 4'b0000};
    tbl[2] = '{4'b1011, 7'h24, 1'b1, 8, 16'h12FF, 4'b1100, 4'b0000};
    tbl[3] = '{4'b1101, 7'h30, 1'b0, 8, 16'h123F, 4'b1110, 4'b0010};
    tbl[4] = '{4'b1110, 7'h19, 1'b1, 8, 16'h1234, 4'b1111, 4'b0010};

    repeat (3) @(negedge clk);
    // reset state while held in reset
    chk("rst_digits", 32'(digits), 32'h0000FFFF);
    chk("rst_valid", 32'(dig_valid), 32'h0);
    chk("rst_cap", 32'(cap_stb), 32'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // table-driven directed vectors
    c0 = cap_cnt; f0 = frame_cnt; b0 = bin_cnt;
    for (int i = 0; i < 5; i++) begin
      hold(tbl[i].a, tbl[i].s, tbl[i].d, tbl[i].n);
      chk("tbl_digits", 32'(digits), 32'(tbl[i].e_dig));
      chk("tbl_valid", 32'(dig_valid), 32'(tbl[i].e_val));
      chk("tbl_dp", 32'(dp_out), 32'(tbl[i].e_dp));
      chk("tbl_err", 32'(dig_err), 32'h0);
      if (i == 0) begin
        chk("first_cap_count", 32'(cap_cnt - c0), 32'd1);
        chk("first_cap_idx", 32'(cap_idx), 32'd3);
      end
    end
    chk("scan_cap_count", 32'(cap_cnt - c0), 32'd5);
    chk("scan_frame_count", 32'(frame_cnt - f0), 32'd1);
`ifdef SEG_SCAN_BIN_EN
    chk("scan_value_bin", 32'(value_bin), 32'd1234);
    chk("scan_bin_count", 32'(bin_cnt - b0), 32'd1);
`else
    chk("scan_value_bin", 32'(value_bin), 32'd0);
    chk("scan_bin_count", 32'(bin_cnt - b0), 32'd0);
`endif

    // glitching pattern on digit 2: never stable long enough
    c0 = cap_cnt;
    for (int i = 0; i < 4; i++) hold(4'b1011, (i % 2) ? 7'h02 : 7'h12, 1'b1, 3);
    chk("glitch_no_cap", 32'(cap_cnt - c0), 32'd0);
    hold(4'b1011, 7'h55, 1'b1, 6);
    chk("illegal_err", 32'(dig_err[2]), 32'd1);
    chk("illegal_nibble_kept", 32'(digits[11:8]), 32'd2);
    chk("illegal_valid", 32'(dig_valid[2]), 32'd0);
    chk("illegal_cap_count", 32'(cap_cnt - c0), 32'd1);

    // ghost events
    c0 = cap_cnt; g0 = int'(ghost_cnt);
    hold(4'b0011, 7'h40, 1'b1, 2);
    hold(4'b1111, 7'h40, 1'b1, 1);
    hold(4'b0101, 7'h40, 1'b1, 2);
    hold(4'b1111, 7'h40, 1'b1, 2);
    chk("ghost_count", 32'(ghost_cnt), 32'(g0 + 2));
    chk("ghost_no_cap", 32'(cap_cnt - c0), 32'd0);

    // timeout on digit 0
    hold(4'b1110, 7'h40, 1'b1, 6);
    chk("tmo_valid_start", 32'(dig_valid[0]), 32'd1);
    an = 4'hF;
    k = 1;
    while (dig_valid[0] && k < 200) begin @(negedge clk); k++; end
    chk("tmo_cycles", 32'(k), 32'd50);
    chk("tmo_digit_kept", 32'(digits[3:0]), 32'd0);

    // randomized traffic against the model, with a mid-run reset
    for (int it = 0; it < 260; it++) begin
      logic [3:0] a;
      logic [6:0] s;
      int r, n;
      r = $urandom_range(0, 9);
      if (r < 7) begin
        case ($urandom_range(0, 3))
          0: a = 4'b0111; 1: a = 4'b1011; 2: a = 4'b1101; default: a = 4'b1110;
        endcase
      end else a = 4'($urandom);
      if ($urandom_range(0, 3) == 0) a = an;
      r = $urandom_range(0, 9);
      s = (r < 8) ? legal[$urandom_range(0, 9)] : (r == 8) ? 7'h7F : 7'($urandom);
      n = $urandom_range(1, 7);
      if ($urandom_range(0, 29) == 0) begin a = 4'hF; n = 60; end
      hold(a, s, 1'($urandom), n);
      if (it == 130) begin
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_digits", 32'(digits), 32'h0000FFFF);
        chk("midrst_valid", 32'(dig_valid), 32'h0);
        chk("midrst_ghost", 32'(ghost_cnt), 32'h0);
        chk("midrst_cap", 32'(cap_stb), 32'h0);
        chk("midrst_frame", 32'(frame_stb), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receive-side counterpart of the 4-digit seven-segment driver. Samples the multiplexed, active-low anode/segment/dp lines and waits for each scanned digit to be stable. Decodes each stable digit back to BCD and keeps a per-digit snapshot with validity and error flags. Used for loopback self-test and as a bench monitor on the display interface.

Parameters:
SETTLE_CYCLES, 4, consecutive identical samples required before a digit is captured (>=1)
TIMEOUT_CYCLES, 2000000, cycles without refresh after which a digit's valid flag clears (20 ms at 100 MHz)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
an  in  [0:3]  anodes, active-low; an[0] selects digit 3 (leftmost), an[3] selects digit 0
seg  in  [0:6]  segments, active-low; seg[0]=G, seg[1]=F ... seg[6]=A
dp  in  1  decimal point, active-low
digits  out  16  BCD nibbles; [15:12]=digit 3 ... [3:0]=digit 0; 4'hF = blank
dig_valid  out  4  per-digit snapshot valid
dig_err  out  4  per-digit illegal-pattern flag
dp_out  out  4  captured dp per digit, active-high
cap_stb  out  1  one-cycle pulse on every capture
cap_idx  out  2  index of the digit captured with cap_stb
frame_stb  out  1  one-cycle pulse when all four digits have been captured since the last pulse
ghost_cnt  out  8  saturating count of multi-anode events
value_bin  out  14  binary value of the frame (optional feature)
bin_stb  out  1  pulse when value_bin updates (optional feature)

Behaviour:
- Reset values: digits=16'hFFFF; all other outputs 0; seen mask 0; age counters 0; FSM in S_IDLE.
- Input stage: an, seg and dp are registered once into an_q, seg_q and dp_q. All logic uses these registered samples.
- A select is valid when exactly one bit of an_q is 0.
- Multi-anode event: the transition into two or more an_q bits low increments ghost_cnt. ghost_cnt saturates at 255.
- FSM states:
  - S_IDLE: on a valid select, load the select, pattern and dp; stab_cnt=1; go to S_SETTLE.
  - S_SETTLE: if an_q/seg_q/dp_q match the loaded values, stab_cnt++. When stab_cnt reaches SETTLE_CYCLES, capture and go to S_HOLD. On any mismatch, reload and restart (stab_cnt=1) if the select is valid, else go to S_IDLE.
  - S_HOLD: stay while the inputs are unchanged; never recapture. On any change, behave as the mismatch case in S_SETTLE.
  - With SETTLE_CYCLES=1, the capture occurs in the S_IDLE cycle itself.
- Latency: inputs held constant from cycle k at the pins cause the capture outputs to update at the edge ending cycle k+SETTLE_CYCLES.
- Capture decode, using the 7-bit hex of seg in [0:6] order:
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9.
  - 7F (all segments off) -> nibble F, valid=1, err=0.
  - Any other pattern: nibble unchanged, valid=0, err=1.
  - dp_out[i] is set to ~dp_q on every capture.
- Capture bookkeeping:
  - cap_stb=1 and cap_idx=i for one cycle.
  - seen[i] is set. If seen becomes 4'hF, assert frame_stb in the same cycle and clear seen.
  - Repeated captures of the same digit do not advance the frame.
- Timeout: each digit has an age counter that clears on its capture and otherwise increments, saturating. When age reaches TIMEOUT_CYCLES, dig_valid[i] clears; digits and dig_err are held.
- Reset mid-operation immediately restores all reset values. A partially settled digit is discarded.

Optional Feature:
Macro SEG_SCAN_BIN_EN.
- Defined: one cycle after frame_stb, value_bin = d3*1000 + d2*100 + d1*10 + d0, with blank nibbles counted as 0, and bin_stb pulses. If any dig_err bit is set at frame_stb, value_bin is held and bin_stb is not asserted. Multipliers are constant shift-add only.
- Undefined: value_bin and bin_stb are tied to 0 and no conversion logic exists.

Test Plan:
- Reset: assert rst_n=0 mid-run -> digits=FFFF, dig_valid=0, ghost_cnt=0, cap_stb=0 on the next sample.
- an=0111, seg=7'h30, dp=1 held 6 cycles (SETTLE=4) -> exactly one cap_stb, cap_idx=3, digits[15:12]=3, dig_valid=1000, dp_out=0000.
- Scan an=0111/1011/1101/1110 with 1,2,3,4 (7'h79,24,30,19), dp=0 on digit 1, 8 cycles each -> digits=16'h1234, single frame_stb on the 4th capture, dp_out=0010, value_bin=1234 with bin_stb (macro on).
- Glitch: valid select with the pattern changing every 3 cycles (SETTLE=4) -> no cap_stb. Then seg=7'h55 stable -> dig_err set for that digit, nibble unchanged, dig_valid clear.
- an=0011 for 2 cycles, then 1111, then 0101 -> ghost_cnt=2, no capture.
- TIMEOUT_CYCLES=50: capture digit 0, then an=1111 -> dig_valid[0] drops exactly 50 cycles after capture, digits[3:0] retained.
